store_write_buffer: RTL and testbench
=====================================

// Module: store_write_buffer
// PURPOSE
//   Posted-store FIFO between the LSB and the byte-wide RAM/IO bus (mem_a/mem_dout/mem_wr).
//   Accepts committed byte/half/word stores and drains them little-endian, one byte per cycle,
//   whenever the read path does not own the bus. Honours io_buffer_full for UART writes
//   (addr[17:16]==2'b11) and flags read-after-pending-write hazards so loads wait.
// PARAMETERS
//   DEPTH   8   store entries; power of two, >=2
//   CNT_W   4   count width = log2(DEPTH)+1
// PORTS
//   clk          in   1      system clock, all state on posedge
//   rst          in   1      reset: asynchronous, active-low (0 = reset)
//   rdy          in   1      global ready; 0 freezes all state
//   wr_valid     in   1      LSB presents a committed store
//   wr_addr      in   32     store byte address (naturally aligned for wr_len)
//   wr_data      in   32     store data, LSB-aligned
//   wr_len       in   2      00 byte, 01 half, 10 word; 11 illegal
//   wr_ready     out  1      entry free; store taken when wr_valid&&wr_ready&&rdy
//   rd_busy      in   1      MemCtrl read owns the bus this cycle
//   rd_chk_addr  in   32     address of the load about to issue
//   rd_hazard    out  1      comb: a pending store overlaps rd_chk_addr's word (or any IO)
//   io_buffer_full in 1      UART tx buffer full
//   mem_a        out  32     bus address (bits 17:0 meaningful)
//   mem_dout     out  8      bus write byte
//   mem_wr       out  1      1 = write this cycle
//   buf_empty    out  1      no pending entries and drain FSM idle
//   buf_count    out  CNT_W  valid entries, 0..DEPTH
// BEHAVIOUR
//   Reset (rst=0, async): head=tail=0, buf_count=0, buf_empty=1, wr_ready=1,
//     mem_wr=0, mem_a=0, mem_dout=0, FSM=IDLE, byte index=0. Reset mid-drain discards all.
//   rdy=0: no enqueue, no dequeue, FSM/pointers hold; mem_wr forced 0 that cycle.
//   Enqueue: entry {addr,data,len}; wr_ready = (buf_count<DEPTH); no full-bypass, i.e. a
//     full buffer rejects even if the head retires the same cycle.
//   Grant g = rdy & ~rd_busy & ~(head_is_io & io_buffer_full).
//   FSM IDLE: if count>0 & g -> DRAIN, drive byte 0 same cycle (mem_wr=1).
//     DRAIN: each cycle with g drive byte k: mem_a=addr+k, mem_dout=data[8k+7:8k], mem_wr=1;
//       last byte (k==1<<len - 1): pop head (count-1, head+1 mod DEPTH), k=0;
//       if head was IO -> IO_GAP, else stay DRAIN if count-1>0 else IDLE.
//       No grant: mem_wr=0, k holds (partial entry resumes, no byte repeated).
//     IO_GAP: one idle cycle (mem_wr=0) so io_buffer_full reflects the last byte -> IDLE.
//   Latency: store accepted at cycle N -> earliest mem_wr at N+1; word = 4 bus cycles.
//   Simultaneous enqueue+pop: count unchanged; pointers wrap mod DEPTH.
//   rd_hazard = OR over valid entries (incl. partially drained head) of
//     entry.addr[31:2]==rd_chk_addr[31:2], or (entry is IO & rd_chk_addr[17:16]==2'b11).
//   wr_len==2'b11 or misaligned address: simulation $error; entry treated as byte.
//   buf_empty = (count==0) & (FSM==IDLE || FSM==IO_GAP).
// CONFIGURATION
//   WBUF_STATS_EN defined: extra outputs stat_io_stall [31:0] (cycles rdy&head_is_io&
//     io_buffer_full while count>0) and stat_full [31:0] (cycles wr_valid&~wr_ready);
//     both reset to 0, saturate at 32'hFFFFFFFF, freeze when rdy=0.
//   Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//   Word store 0x0000_1000 <- 0xDDCCBBAA, rd_busy=0 -> mem_wr 4 cycles: (1000,AA),(1001,BB),
//     (1002,CC),(1003,DD); buf_empty=1 the cycle after.
//   8 word stores back-to-back, no grant (rd_busy=1) -> count=8, wr_ready=0, 9th held;
//     release -> 32 byte writes in FIFO order, wr_ready=1 after first pop.
//   Byte store 0x30000 <- 0x41 with io_buffer_full=1 for 5 cycles -> mem_wr=0 for 5 cycles,
//     then (30000,41), then one IO_GAP cycle with mem_wr=0.
//   Pending half store at 0x2002; rd_chk_addr=0x2000 -> rd_hazard=1; 0x2004 -> 0;
//     after last byte pops -> rd_hazard=0.
//   Word drain, rd_busy=1 after byte 1 for 3 cycles -> bytes 2,3 resume, no repeats;
//     rst pulse low mid-drain -> mem_wr=0, count=0 immediately.

Source files
------------

// File: rtl/store_write_buffer.sv
// Posted-store FIFO that drains committed byte/half/word stores onto the byte-wide memory bus.
// Optional WBUF_STATS_EN adds stat_io_stall / stat_full event counters.
module store_write_buffer #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             wr_valid,
   input  logic [31:0]      wr_addr,
   input  logic [31:0]      wr_data,
   input  logic [1:0]       wr_len,
   output logic             wr_ready,
   input  logic             rd_busy,
   input  logic [31:0]      rd_chk_addr,
   output logic             rd_hazard,
   input  logic             io_buffer_full,
   output logic [31:0]      mem_a,
   output logic [7:0]       mem_dout,
   output logic             mem_wr,
   output logic             buf_empty,
   output logic [CNT_W-1:0] buf_count
`ifdef WBUF_STATS_EN
   ,
   output logic [31:0]      stat_io_stall,
   output logic [31:0]      stat_full
`endif
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRAIN  = 2'd1,
      IO_GAP = 2'd2
   } state_t;

   logic [31:0]      entry_addr [DEPTH];
   logic [31:0]      entry_data [DEPTH];
   logic [1:0]       entry_len  [DEPTH];
   logic [DEPTH-1:0] entry_valid;

   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count;
   logic [1:0]       byte_idx, byte_idx_nxt;
   state_t           state, state_nxt;

   logic        push, pop, drive, grant;
   logic        bad_store;
   logic [1:0]  eff_len;
   logic [31:0] head_addr, head_data;
   logic [1:0]  head_len, last_idx;
   logic        head_is_io, last_byte;
   logic        unused_bits;

   assign unused_bits = ^rd_chk_addr[1:0];

   // Illegal lengths and misaligned addresses degrade to a single byte store.
   assign bad_store = (wr_len == 2'b11) ||
                      ((wr_len == 2'b01) && wr_addr[0]) ||
                      ((wr_len == 2'b10) && (wr_addr[1:0] != 2'b00));
   assign eff_len   = bad_store ? 2'b00 : wr_len;

   assign wr_ready  = (count < CNT_W'(DEPTH));
   assign push      = wr_valid && wr_ready && rdy;

   assign head_addr  = entry_addr[head];
   assign head_data  = entry_data[head];
   assign head_len   = entry_len[head];
   assign head_is_io = (count != '0) && (head_addr[17:16] == 2'b11);
   assign grant      = rdy && !rd_busy && !(head_is_io && io_buffer_full);

   always_comb begin
      last_idx = 2'd0;
      case (head_len)
         2'b01:   last_idx = 2'd1;
         2'b10:   last_idx = 2'd3;
         default: last_idx = 2'd0;
      endcase
   end

   assign last_byte = (byte_idx == last_idx);

   // Drain FSM: byte 0 goes out in the same cycle IDLE sees a granted, non-empty buffer.
   always_comb begin
      state_nxt    = state;
      drive        = 1'b0;
      pop          = 1'b0;
      byte_idx_nxt = byte_idx;
      case (state)
         IDLE: begin
            if ((count != '0) && grant) begin
               drive     = 1'b1;
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (grant) drive = 1'b1;
         end
         IO_GAP: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (drive) begin
         if (last_byte) begin
            pop          = 1'b1;
            byte_idx_nxt = 2'd0;
            if (head_is_io)
               state_nxt = IO_GAP;
            else if (count > CNT_W'(1))
               state_nxt = DRAIN;
            else
               state_nxt = IDLE;
         end else begin
            byte_idx_nxt = byte_idx + 2'd1;
         end
      end
   end

   always_comb begin
      mem_wr   = drive;
      mem_a    = 32'd0;
      mem_dout = 8'd0;
      if (drive) begin
         mem_a = head_addr + {30'd0, byte_idx};
         case (byte_idx)
            2'd0:    mem_dout = head_data[7:0];
            2'd1:    mem_dout = head_data[15:8];
            2'd2:    mem_dout = head_data[23:16];
            default: mem_dout = head_data[31:24];
         endcase
      end
   end

   // Control state; rdy=0 freezes everything, and reset discards any partial drain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         byte_idx    <= 2'd0;
         state       <= IDLE;
         entry_valid <= '0;
      end else if (rdy) begin
         state    <= state_nxt;
         byte_idx <= byte_idx_nxt;
         if (push) begin
            tail              <= tail + PTR_W'(1);
            entry_valid[tail] <= 1'b1;
         end
         if (pop) begin
            head              <= head + PTR_W'(1);
            entry_valid[head] <= 1'b0;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         entry_addr[tail] <= wr_addr;
         entry_data[tail] <= wr_data;
         entry_len[tail]  <= eff_len;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && push)
         assert (!bad_store)
            else $error("store_write_buffer: illegal store len=%b addr=%h", wr_len, wr_addr);
   end

   // Loads wait on any pending store to the same word, including a partly drained head.
   always_comb begin
      rd_hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i] &&
             ((entry_addr[i][31:2] == rd_chk_addr[31:2]) ||
              ((entry_addr[i][17:16] == 2'b11) && (rd_chk_addr[17:16] == 2'b11))))
            rd_hazard = 1'b1;
      end
   end

   assign buf_count = count;
   assign buf_empty = (count == '0) && ((state == IDLE) || (state == IO_GAP));

`ifdef WBUF_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_io_stall <= 32'd0;
         stat_full     <= 32'd0;
      end else if (rdy) begin
         if (head_is_io && io_buffer_full && (stat_io_stall != 32'hFFFF_FFFF))
            stat_io_stall <= stat_io_stall + 32'd1;
         if (wr_valid && !wr_ready && (stat_full != 32'hFFFF_FFFF))
            stat_full <= stat_full + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: a scoreboard of expected bus bytes plus state checks.
module tb_store_write_buffer;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        wr_valid;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic [1:0]  wr_len;
   logic        wr_ready;
   logic        rd_busy;
   logic [31:0] rd_chk_addr;
   logic        rd_hazard;
   logic        io_buffer_full;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout;
   logic        mem_wr;
   logic        buf_empty;
   logic [3:0]  buf_count;

   int          checks = 0;
   int          errors = 0;
   logic [39:0] sbQ[$];
   int          waitCnt;

   store_write_buffer #(.DEPTH(8), .CNT_W(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .wr_valid       (wr_valid),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .wr_len         (wr_len),
      .wr_ready       (wr_ready),
      .rd_busy        (rd_busy),
      .rd_chk_addr    (rd_chk_addr),
      .rd_hazard      (rd_hazard),
      .io_buffer_full (io_buffer_full),
      .mem_a          (mem_a),
      .mem_dout       (mem_dout),
      .mem_wr         (mem_wr),
      .buf_empty      (buf_empty),
      .buf_count      (buf_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
         end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Little-endian byte sequence a store should produce on the bus.
   task automatic pushExpected(input logic [31:0] a, input logic [31:0] d, input logic [1:0] l);
      int n;
      n = 1 << l;
      for (int k = 0; k < n; k++)
         sbQ.push_back({a + 32'(k), d[8*k +: 8]});
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [1:0] l);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      wr_len   = l;
      pushExpected(a, d, l);
      cyc();
      wr_valid = 1'b0;
   endtask

   // Bus monitor: every write must match the head of the scoreboard.
   initial begin
      logic [39:0] exp;
      forever begin
         @(negedge clk);
         if (mem_wr === 1'b1) begin
            if (sbQ.size() == 0) begin
               checks++;
               errors++;
               $error("[TB] FAIL unexpected_write observed=%h/%h expected=none", mem_a, mem_dout);
            end else begin
               exp = sbQ.pop_front();
               checkOutput("bus_addr", mem_a, exp[39:8]);
               checkOutput("bus_byte", {24'd0, mem_dout}, {24'd0, exp[7:0]});
            end
         end
      end
   end

   initial begin
      rst = 1'b1; rdy = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_len = '0;
      rd_busy = 1'b0; rd_chk_addr = '0; io_buffer_full = 1'b0;
      #2 rst = 1'b0;
      cyc(); cyc();
      checkOutput("rst_count", 32'(buf_count), 32'd0);
      checkOutput("rst_empty", 32'(buf_empty), 32'd1);
      checkOutput("rst_ready", 32'(wr_ready), 32'd1);
      checkOutput("rst_mem_wr", 32'(mem_wr), 32'd0);
      checkOutput("rst_mem_a", mem_a, 32'd0);
      checkOutput("rst_dout", 32'(mem_dout), 32'd0);
      rst = 1'b1;
      cyc();

      $display("[TB] word store drain");
      applyStimulus(32'h0000_1000, 32'hDDCC_BBAA, 2'b10);
      checkOutput("w_count", 32'(buf_count), 32'd1);
      checkOutput("w_first_wr", 32'(mem_wr), 32'd1);
      checkOutput("w_first_a", mem_a, 32'h0000_1000);
      checkOutput("w_first_d", 32'(mem_dout), 32'hAA);
      cyc(); cyc(); cyc(); cyc();
      checkOutput("w_empty_after", 32'(buf_empty), 32'd1);
      checkOutput("w_idle_wr", 32'(mem_wr), 32'd0);

      $display("[TB] fill to full without grant");
      rd_busy = 1'b1;
      for (int i = 0; i < 8; i++)
         applyStimulus(32'h0000_8000 + 32'(i) * 32'h10, 32'h0403_0201 + 32'(i) * 32'h1010_1010, 2'b10);
      checkOutput("full_count", 32'(buf_count), 32'd8);
      checkOutput("full_ready", 32'(wr_ready), 32'd0);
      checkOutput("full_no_wr", 32'(mem_wr), 32'd0);
      wr_valid = 1'b1; wr_addr = 32'h0000_9000; wr_data = 32'hCAFE_F00D; wr_len = 2'b10;
      cyc(); cyc();
      checkOutput("ninth_held", 32'(buf_count), 32'd8);
      rd_busy = 1'b0;
      waitCnt = 0;
      while (wr_ready !== 1'b1 && waitCnt < 20) begin
         cyc();
         waitCnt++;
      end
      checkOutput("ready_after_pop", 32'(waitCnt), 32'd4);
      pushExpected(32'h0000_9000, 32'hCAFE_F00D, 2'b10);
      cyc();
      wr_valid = 1'b0;
      checkOutput("ninth_taken", 32'(buf_count), 32'd8);
      waitCnt = 0;
      while (buf_empty !== 1'b1 && waitCnt < 100) begin
         cyc();
         waitCnt++;
      end
      checkOutput("full_drained", 32'(buf_empty), 32'd1);
      checkOutput("full_sb_empty", 32'(sbQ.size()), 32'd0);

      $display("[TB] IO store with UART full");
      io_buffer_full = 1'b1;
      applyStimulus(32'h0003_0000, 32'h0000_0041, 2'b00);
      rd_chk_addr = 32'h0003_1230;
      #1;
      checkOutput("io_hazard", 32'(rd_hazard), 32'd1);
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("io_stall_%0d", i), 32'(mem_wr), 32'd0);
         cyc();
      end
      io_buffer_full = 1'b0;
      #1;
      checkOutput("io_wr", 32'(mem_wr), 32'd1);
      checkOutput("io_a", mem_a, 32'h0003_0000);
      checkOutput("io_d", 32'(mem_dout), 32'h41);
      cyc();
      checkOutput("io_gap_wr", 32'(mem_wr), 32'd0);
      checkOutput("io_gap_empty", 32'(buf_empty), 32'd1);
      checkOutput("io_hazard_clear", 32'(rd_hazard), 32'd0);
      cyc();

      $display("[TB] read-after-write hazard");
      rd_busy = 1'b1;
      applyStimulus(32'h0000_2002, 32'h0000_BEEF, 2'b01);
      rd_chk_addr = 32'h0000_2000;
      #1;
      checkOutput("haz_same_word", 32'(rd_hazard), 32'd1);
      rd_chk_addr = 32'h0000_2004;
      #1;
      checkOutput("haz_next_word", 32'(rd_hazard), 32'd0);
      rd_chk_addr = 32'h0000_2000;
      rd_busy = 1'b0;
      #1;
      checkOutput("haz_byte0_a", mem_a, 32'h0000_2002);
      cyc();
      checkOutput("haz_partial", 32'(rd_hazard), 32'd1);
      cyc();
      checkOutput("haz_popped", 32'(rd_hazard), 32'd0);

      $display("[TB] drain interrupted by reads");
      applyStimulus(32'h0000_4000, 32'h4433_2211, 2'b10);
      cyc();
      checkOutput("int_byte1_a", mem_a, 32'h0000_4001);
      cyc();
      rd_busy = 1'b1;
      #1;
      checkOutput("int_busy0", 32'(mem_wr), 32'd0);
      cyc();
      checkOutput("int_busy1", 32'(mem_wr), 32'd0);
      cyc();
      checkOutput("int_busy2", 32'(mem_wr), 32'd0);
      cyc();
      rd_busy = 1'b0;
      #1;
      checkOutput("int_resume_a", mem_a, 32'h0000_4002);
      checkOutput("int_resume_d", 32'(mem_dout), 32'h33);
      cyc();
      checkOutput("int_last_d", 32'(mem_dout), 32'h44);
      cyc();
      checkOutput("int_empty", 32'(buf_empty), 32'd1);

      $display("[TB] rdy low freezes");
      applyStimulus(32'h0000_6000, 32'h0000_A55A, 2'b01);
      cyc();
      rdy = 1'b0;
      #1;
      checkOutput("rdy_no_wr", 32'(mem_wr), 32'd0);
      cyc();
      checkOutput("rdy_hold_count", 32'(buf_count), 32'd1);
      rdy = 1'b1;
      #1;
      checkOutput("rdy_resume_a", mem_a, 32'h0000_6001);
      checkOutput("rdy_resume_d", 32'(mem_dout), 32'hA5);
      cyc();
      rdy = 1'b0; wr_valid = 1'b1; wr_addr = 32'h0000_7000; wr_data = 32'h11; wr_len = 2'b00;
      cyc();
      wr_valid = 1'b0; rdy = 1'b1;
      #1;
      checkOutput("rdy_no_enq", 32'(buf_count), 32'd0);

      $display("[TB] reset mid-drain");
      applyStimulus(32'h0000_5000, 32'h8877_6655, 2'b10);
      cyc();
      rst = 1'b0;
      #1;
      checkOutput("mid_rst_wr", 32'(mem_wr), 32'd0);
      checkOutput("mid_rst_count", 32'(buf_count), 32'd0);
      checkOutput("mid_rst_empty", 32'(buf_empty), 32'd1);
      sbQ.delete();
      cyc();
      rst = 1'b1;
      cyc();
      checkOutput("post_rst_wr", 32'(mem_wr), 32'd0);
      checkOutput("final_sb_empty", 32'(sbQ.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
